// File: rtl/fx_gate_scheduler.sv
// Gate-window sequencer in the measured-clock domain: PRE guard, gate of selectable length, POST guard, then ack wait.
// gate rises GUARD_PRE cycles after an accepted start; done follows the synchronised ack edge; start is ignored while busy.
module fx_gate_scheduler #(
    parameter int unsigned GUARD_PRE   = 10,
    parameter int unsigned GUARD_POST  = 10,
    parameter int unsigned GATE_T0     = 1000,
    parameter int unsigned GATE_T1     = 10000,
    parameter int unsigned GATE_T2     = 50000,
    parameter int unsigned GATE_T3     = 500000,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic        clk_fx,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  range_sel,
    input  logic        meas_ack,
    output logic        gate,
    output logic        busy,
    output logic [31:0] gate_cycles,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        GATE,
        POST,
        WAIT_ACK
    } state_t;

    // Terminal counts: cnt runs 0..N-1 inside a state, so the last cycle compares against N-1.
    localparam logic [31:0] PRE_LAST  = 32'(GUARD_PRE) - 32'd1;
    localparam logic [31:0] POST_LAST = 32'(GUARD_POST) - 32'd1;
    localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT) - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] gate_len;
    logic        ack_s1;
    logic        ack_s2;
    logic        ack_s3;
    logic        ack_rise;

    function automatic logic [31:0] len_for(input logic [1:0] sel);
        logic [31:0] len;
        case (sel)
            2'd0:    len = 32'(GATE_T0);
            2'd1:    len = 32'(GATE_T1);
            2'd2:    len = 32'(GATE_T2);
            default: len = 32'(GATE_T3);
        endcase
        return len;
    endfunction

    // meas_ack comes from the reference-clock domain; only its synchronised rising edge is used.
    always_ff @(posedge clk_fx or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_s3 <= 1'b0;
        end else begin
            ack_s1 <= meas_ack;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
        end
    end

    assign ack_rise = ack_s2 & ~ack_s3;

    always_ff @(posedge clk_fx or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            gate_len    <= '0;
            gate        <= 1'b0;
            busy        <= 1'b0;
            gate_cycles <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state    <= PRE;
                        busy     <= 1'b1;
                        gate_len <= len_for(range_sel);
                        timeout  <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= GATE;
                        gate  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                GATE: begin
                    if (cnt == gate_len - 32'd1) begin
                        state       <= POST;
                        gate        <= 1'b0;
                        gate_cycles <= gate_len;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                POST: begin
                    if (cnt == POST_LAST) begin
                        state <= WAIT_ACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_ACK: begin
                    // Ack wins over the timeout check when both land on the same cycle.
                    if (ack_rise) begin
                        done <= 1'b1;
                        cnt  <= '0;
                        if (continuous) begin
                            state    <= PRE;
                            gate_len <= len_for(range_sel);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (cnt == ACK_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gate  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx_gate_scheduler.sv
// Bench for fx_gate_scheduler: each run's gate/done/busy/timeout timeline is computed arithmetically
// from the start edge, gate lengths and ack delays, then compared cycle by cycle against the outputs.
module tb_fx_gate_scheduler;

    localparam int GP  = 10;
    localparam int GPO = 12;
    localparam int T0  = 1000;
    localparam int T1  = 1500;
    localparam int T2  = 2000;
    localparam int T3  = 3000;
    localparam int AT  = 2500;

    logic        clk_fx = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  range_sel = 2'd0;
    logic        meas_ack = 1'b0;
    logic        gate;
    logic        busy;
    logic [31:0] gate_cycles;
    logic        done;
    logic        timeout;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int exp_gc = 0;
    bit exp_to = 1'b0;

    fx_gate_scheduler #(
        .GUARD_PRE  (GP),
        .GUARD_POST (GPO),
        .GATE_T0    (T0),
        .GATE_T1    (T1),
        .GATE_T2    (T2),
        .GATE_T3    (T3),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk_fx     (clk_fx),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .range_sel  (range_sel),
        .meas_ack   (meas_ack),
        .gate       (gate),
        .busy       (busy),
        .gate_cycles(gate_cycles),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk_fx = ~clk_fx;

    function automatic int len_of(input int r);
        case (r)
            0:       return T0;
            1:       return T1;
            2:       return T2;
            default: return T3;
        endcase
    endfunction

    function automatic string sig_name(input int j);
        case (j)
            0:       return "gate";
            1:       return "busy";
            2:       return "done";
            3:       return "gate_cycles";
            default: return "timeout";
        endcase
    endfunction

    // Advance one clock; afterwards cyc is the number of the edge just taken.
    task automatic step();
        @(posedge clk_fx);
        #1;
        cyc++;
    endtask

    // One start followed by n windows. Window i starts on edge p (the start or the previous done edge),
    // gate is high on samples [p+GP, p+GP+len), ack is driven ds[i] cycles after the POST guard ends,
    // and done follows the drive by 3 edges (two synchroniser flops plus the edge detect).
    task automatic run_schedule(input string name, input int n, input int rs[4], input int ds[4],
                                input bit no_ack_last, input bit noise, input bit stale, input bit start_noise);
        int p[4];
        int r[4];
        int f[4];
        int a[4];
        int d[4];
        int l[4];
        int s0;
        int last;
        int endc;
        int tmo;
        int k;
        int err[5];
        int fc[5];
        logic [31:0] got[5];
        logic [31:0] want[5];
        logic [31:0] obs[5];
        logic [31:0] expv[5];
        bit e_gate;
        bit e_done;
        bit ack_v;

        last = n - 1;
        s0   = cyc + 1;
        tmo  = -1;
        for (int i = 0; i < n; i++) begin
            p[i] = (i == 0) ? s0 : d[i-1];
            l[i] = len_of(rs[i]);
            r[i] = p[i] + GP;
            f[i] = r[i] + l[i];
            a[i] = f[i] + GPO + ds[i];
            d[i] = a[i] + 3;
        end
        if (no_ack_last) begin
            tmo  = f[last] + GPO + AT;
            endc = tmo;
        end else begin
            endc = d[last];
        end
        for (int j = 0; j < 5; j++) begin
            err[j] = 0;
            fc[j]  = 0;
            got[j] = '0;
            want[j] = '0;
        end

        start      = 1'b1;
        range_sel  = 2'(rs[0]);
        continuous = (n > 1);
        meas_ack   = 1'b0;

        for (int c = s0; c <= endc + 20; c++) begin
            step();
            e_gate = 1'b0;
            e_done = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (c >= r[i] && c < f[i]) e_gate = 1'b1;
                if (c == d[i] && !(no_ack_last && i == last)) e_done = 1'b1;
                if (c == f[i]) exp_gc = l[i];
            end
            exp_to = (tmo >= 0 && c >= tmo);
            obs[0] = 32'(gate);
            obs[1] = 32'(busy);
            obs[2] = 32'(done);
            obs[3] = gate_cycles;
            obs[4] = 32'(timeout);
            expv[0] = 32'(e_gate);
            expv[1] = 32'(c < endc);
            expv[2] = 32'(e_done);
            expv[3] = 32'(exp_gc);
            expv[4] = 32'(exp_to);
            for (int j = 0; j < 5; j++) begin
                if (obs[j] !== expv[j]) begin
                    if (err[j] == 0) begin
                        fc[j]   = c;
                        got[j]  = obs[j];
                        want[j] = expv[j];
                    end
                    err[j]++;
                end
            end

            // Inputs for edge c+1.
            start = 1'b0;
            if (c + 1 <= endc) begin
                if (noise) begin
                    start = ($urandom_range(0, 99) < 3);
                end else if (start_noise) begin
                    for (int i = 0; i < n; i++)
                        if (c + 1 == p[i] + 2 || c + 1 == r[i] + 3 || c + 1 == f[i] + 2) start = 1'b1;
                end
            end
            if (noise) begin
                range_sel = 2'($urandom_range(0, 3));
                for (int i = 0; i < n; i++)
                    if (c + 1 == p[i]) range_sel = 2'(rs[i]);
                continuous = 1'($urandom_range(0, 1));
                for (int i = 0; i < n; i++)
                    if (c + 1 == d[i]) continuous = (i < last);
            end else begin
                k = 0;
                for (int i = 0; i < last; i++)
                    if (c + 1 >= r[i] + l[i] / 2) k = i + 1;
                range_sel  = 2'(rs[k]);
                continuous = (n > 1) && (c + 1 < r[last] + l[last] / 2);
            end
            ack_v = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!(no_ack_last && i == last) && c >= a[i] && c < a[i] + 4) ack_v = 1'b1;
                if (stale && c >= r[i] + l[i] / 3 && c < r[i] + l[i] / 3 + 4) ack_v = 1'b1;
            end
            meas_ack = ack_v;
        end
        start    = 1'b0;
        meas_ack = 1'b0;

        for (int j = 0; j < 5; j++) begin
            tests++;
            if (err[j] !== 0) begin
                fails++;
                $display("FAIL %s/%s: %0d bad cycles, first at cycle %0d got %0d expected %0d",
                         name, sig_name(j), err[j], fc[j] - s0, got[j], want[j]);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        step();
        step();
        tests++; if (gate !== 1'b0) begin fails++; $display("FAIL reset/gate: got %b expected 0", gate); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset/busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset/done: got %b expected 0", done); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset/timeout: got %b expected 0", timeout); end
        tests++; if (gate_cycles !== 32'd0) begin fails++; $display("FAIL reset/gate_cycles: got %0d expected 0", gate_cycles); end
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (gate !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL reset_idle: %0d active cycles expected 0", bad); end
    endtask

    task automatic test_single();
        run_schedule("single", 1, '{0, 0, 0, 0}, '{30, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_continuous_ranging();
        run_schedule("continuous", 3, '{2, 2, 1, 0}, '{5, 17, 9, 0}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_schedule("timeout", 1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, 1'b0, 1'b0, 1'b0);
        run_schedule("after_timeout", 1, '{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_and_stale();
        run_schedule("start_stale", 1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        int s0;
        int bad;
        bad = 0;
        s0 = cyc + 1;
        start = 1'b1;
        range_sel = 2'd0;
        continuous = 1'b0;
        meas_ack = 1'b0;
        step();
        start = 1'b0;
        while (cyc < s0 + GP + 500) step();
        tests++; if (gate !== 1'b1) begin fails++; $display("FAIL mid_window_gate: got %b expected 1", gate); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (gate !== 1'b0) begin fails++; $display("FAIL arst/gate: got %b expected 0", gate); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst/busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL arst/done: got %b expected 0", done); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL arst/timeout: got %b expected 0", timeout); end
        tests++; if (gate_cycles !== 32'd0) begin fails++; $display("FAIL arst/gate_cycles: got %0d expected 0", gate_cycles); end
        step();
        step();
        rst_n = 1'b1;
        repeat (40) begin
            step();
            if (gate !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL arst_idle: %0d active cycles expected 0", bad); end
        exp_gc = 0;
        exp_to = 1'b0;
    endtask

    task automatic test_continuous_drop();
        run_schedule("cont_drop", 2, '{0, 0, 0, 0}, '{3, 3, 0, 0}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int rs[4];
        int ds[4];
        int n;
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < 4; i++) begin
                rs[i] = $urandom_range(0, 3);
                ds[i] = $urandom_range(0, 150);
            end
            run_schedule($sformatf("random%0d", t), n, rs, ds, ($urandom_range(0, 3) == 0),
                         1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous_ranging();
        test_timeout();
        test_start_and_stale();
        test_async_reset();
        test_continuous_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fx_gate_scheduler.md
Name: fx_gate_scheduler

Overview:
Measurement sequencer for the equal-precision frequency meter, running entirely in the measured-clock domain (clk_fx). It generates the gate window with a software-selectable length and guard intervals. It waits for the reference-clock side to acknowledge that its count and division are finished, then re-arms, either single-shot or continuously. It replaces the free-running gate counter and adds ranging, handshake and timeout.

Parameters:
GUARD_PRE, 10, clk_fx cycles gate stays low before each window
GUARD_POST, 10, clk_fx cycles gate stays low after each window before ack wait
GATE_T0, 1000, gate length in clk_fx cycles for range_sel=0
GATE_T1, 10000, gate length for range_sel=1
GATE_T2, 50000, gate length for range_sel=2
GATE_T3, 500000, gate length for range_sel=3
ACK_TIMEOUT, 65535, max clk_fx cycles spent in WAIT_ACK

Ports:
clk_fx  in  1  measured clock, sole clock of the block
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a measurement (sync to clk_fx)
continuous  in  1  level; 1 = auto re-arm after each completed measurement
range_sel  in  2  gate length select (GATE_T0..GATE_T3)
meas_ack  in  1  level from clk_fs domain, asynchronous; rises when reference side has latched its count
gate  out  1  registered gate window to the counting datapath
busy  out  1  high in any state other than IDLE
gate_cycles  out  32  number of clk_fx cycles gate was high in the last window
done  out  1  one-cycle pulse: measurement complete and acknowledged
timeout  out  1  sticky: ack not received within ACK_TIMEOUT

Behaviour:
- Reset (async, any time, including mid-window): state=IDLE, gate=0, busy=0, gate_cycles=0, done=0, timeout=0, counter=0, sync flops=0.
- meas_ack is passed through a 2-flop synchronizer, then a third flop for rising-edge detect. Only the synchronized rising edge counts as an ack.
- One 32-bit down/up counter cnt is shared by all timed states. gate_len is 32 bits, selected from range_sel.
- States and transitions:
  - IDLE: start=1 -> PRE. Latch gate_len from range_sel and clear timeout. cnt=0.
  - PRE: gate=0. Exit to GATE after exactly GUARD_PRE cycles in PRE. cnt reloads 0.
  - GATE: gate=1 on every cycle in this state, for exactly gate_len cycles. On the last cycle, latch gate_cycles=gate_len and go to POST.
  - POST: gate=0 for GUARD_POST cycles, then WAIT_ACK.
  - WAIT_ACK: on the ack rising edge, pulse done for 1 cycle. If continuous=1 at that edge, go to PRE and re-latch gate_len from the current range_sel; otherwise go to IDLE.
  - WAIT_ACK timeout: if cnt reaches ACK_TIMEOUT with no ack, set timeout=1, no done, go to IDLE regardless of continuous.
- gate is a flop output: it goes high on the first clk_fx edge of GATE and low on the first edge of POST. It has no glitches and no combinational path from inputs.
- start while busy=1 is ignored. start and ack on the same cycle in WAIT_ACK: the ack is serviced and start is ignored.
- An ack edge arriving outside WAIT_ACK is discarded. It must not satisfy a later WAIT_ACK.
- Changes to range_sel are ignored between latch points. Deasserting continuous mid-measurement completes the current measurement, then goes to IDLE.
- timeout stays 1 until the next accepted start or reset.
- Counter comparisons are width-safe: parameters are zero-extended to 32 bits, and GATE_T3 must be less than 2^32.

Test Plan:
- Reset then start, range_sel=0, continuous=0; ack 30 cycles after POST ends -> gate low 10 cycles, high exactly 1000 cycles, low; gate_cycles=1000; done one pulse; busy returns 0.
- range_sel=2, continuous=1, ack returned for each window; range_sel changed to 1 during the second window -> second window 50000 cycles, third window 10000 cycles; done pulses once per window.
- No ack in WAIT_ACK -> after 65535 cycles timeout=1, no done, IDLE. A new start clears timeout and a normal run follows.
- start pulses during PRE, GATE and POST -> ignored, single window only. Ack pulse injected during GATE, then none -> timeout raised (stale ack discarded).
- rst_n asserted 500 cycles into a range_sel=0 window -> gate=0 asynchronously, all outputs 0. After release, the block stays in IDLE until start.
- continuous dropped during GATE of a continuous run -> that measurement finishes with done, then IDLE, busy=0, no further gate.
